// File: rtl/ddr2_refresh_credit_monitor_pkg.sv
// Shared definitions for the DDR2 refresh credit monitor: REF command
// encoding and the signed credit saturation limit.
package ddr2_mon_pkg;

  // {CS#, RAS#, CAS#, WE#} for AUTO REFRESH
  localparam logic [3:0] CMD_REF = 4'b0001;

  function automatic logic is_ref_cmd(input logic cs_n, input logic ras_n,
                                      input logic cas_n, input logic we_n);
    return ({cs_n, ras_n, cas_n, we_n} == CMD_REF);
  endfunction

  // Largest magnitude a signed credit of width w may hold; the negative
  // limit is the mirror image so the range stays symmetric.
  function automatic int cred_sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/ddr2_refresh_credit_monitor_rank_tracker.sv
// Per-rank refresh bookkeeping: signed credit, REF spacing timer, REF event
// counter and the three sticky error flags for one chip-select.
module ddr2_ref_rank_tracker
  import ddr2_mon_pkg::*;
#(
  parameter int TRFC_CLK     = 26,
  parameter int MAX_POSTPONE = 8,
  parameter int MAX_PULLIN   = 8,
  parameter int CRED_W       = 5,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     clear_i,
  input  logic                     tick_i,
  input  logic                     ref_hit_i,
  output logic signed [CRED_W-1:0] credit_o,
  output logic [CNT_W-1:0]         ref_count_o,
  output logic                     err_postpone_o,
  output logic                     err_pullin_o,
  output logic                     err_trfc_o,
  output logic                     err_next_o
);

  localparam int SPC_W = $clog2(TRFC_CLK + 1);

  localparam logic signed [CRED_W-1:0] CRED_MAX = CRED_W'(cred_sat_max(CRED_W));
  localparam logic signed [CRED_W-1:0] CRED_MIN = -CRED_MAX;
  localparam logic signed [CRED_W-1:0] POST_LIM = CRED_W'(MAX_POSTPONE);
  localparam logic signed [CRED_W-1:0] PULL_LIM = CRED_W'(-MAX_PULLIN);
  localparam logic [SPC_W-1:0]         SPC_SAT  = SPC_W'(TRFC_CLK);
  localparam logic [SPC_W-1:0]         SPC_MIN  = SPC_W'(TRFC_CLK - 1);

  logic signed [CRED_W-1:0] credit_q, credit_d;
  logic [SPC_W-1:0]         spc_q, spc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     post_q, post_d;
  logic                     pull_q, pull_d;
  logic                     trfc_q, trfc_d;

  // Next-state: saturating credit, spacing timer, counter and sticky flags.
  // The credit limits are compared on the registered credit, so a limit
  // crossing is flagged one cycle after the credit itself moves.
  always_comb begin
    credit_d = credit_q;
    if (tick_i && !ref_hit_i && credit_q != CRED_MAX)
      credit_d = credit_q + CRED_W'(1);
    else if (ref_hit_i && !tick_i && credit_q != CRED_MIN)
      credit_d = credit_q - CRED_W'(1);

    spc_d = spc_q;
    if (ref_hit_i)
      spc_d = '0;
    else if (spc_q != SPC_SAT)
      spc_d = spc_q + SPC_W'(1);

    cnt_d = cnt_q;
    if (ref_hit_i && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);

    post_d = post_q | (credit_q > POST_LIM);
    pull_d = pull_q | (credit_q < PULL_LIM);
    trfc_d = trfc_q | (ref_hit_i && (spc_q < SPC_MIN));
  end

  // State registers; clearing saturates the spacing timer so the first REF
  // after enable is never a spacing error.
  always_ff @(posedge clk) begin
    if (clear_i) begin
      credit_q <= '0;
      spc_q    <= SPC_SAT;
      cnt_q    <= '0;
      post_q   <= 1'b0;
      pull_q   <= 1'b0;
      trfc_q   <= 1'b0;
    end else begin
      credit_q <= credit_d;
      spc_q    <= spc_d;
      cnt_q    <= cnt_d;
      post_q   <= post_d;
      pull_q   <= pull_d;
      trfc_q   <= trfc_d;
    end
  end

  assign credit_o       = credit_q;
  assign ref_count_o    = cnt_q;
  assign err_postpone_o = post_q;
  assign err_pullin_o   = pull_q;
  assign err_trfc_o     = trfc_q;
  assign err_next_o     = !clear_i && (post_d || pull_d || trfc_d);

endmodule

// File: rtl/ddr2_refresh_credit_monitor.sv
// Passive multi-rank DDR2 AUTO REFRESH checker. Decodes REF per chip-select,
// generates the tREFI obligation tick and records which rank erred first.
module ddr2_refresh_credit_monitor
  import ddr2_mon_pkg::*;
#(
  parameter int NUM_RANKS    = 2,
  parameter int TREFI_CLK    = 7800,
  parameter int TRFC_CLK     = 26,
  parameter int MAX_POSTPONE = 8,
  parameter int MAX_PULLIN   = 8,
  parameter int CRED_W       = 5,
  parameter int CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ready_i,
  input  logic                          cke_pad,
  input  logic [NUM_RANKS-1:0]          csbar_pad,
  input  logic                          rasbar_pad,
  input  logic                          casbar_pad,
  input  logic                          webar_pad,
  output logic [NUM_RANKS*CRED_W-1:0]   credit_o,
  output logic [NUM_RANKS*CNT_W-1:0]    ref_count_o,
  output logic [NUM_RANKS-1:0]          err_postpone_o,
  output logic [NUM_RANKS-1:0]          err_pullin_o,
  output logic [NUM_RANKS-1:0]          err_trfc_o,
  output logic                          err_any_o,
  output logic [2:0]                    first_err_rank_o
);

  localparam int TMR_W = (TREFI_CLK > 2) ? $clog2(TREFI_CLK) : 1;
  localparam logic [TMR_W-1:0] TICK_LAST = TMR_W'(TREFI_CLK - 1);

  logic                 clear;
  logic                 run;
  logic                 tick;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [NUM_RANKS-1:0] ref_hit;
  logic [NUM_RANKS-1:0] err_next;
  logic                 err_any_q, err_any_d;
  logic [2:0]           first_q, first_d;

  // Dropping ready is treated exactly like reset.
  assign clear = reset || !ready_i;
  assign run   = ready_i && cke_pad;
  assign tick  = run && (tmr_q == TICK_LAST);

  // REF decode per chip-select; several ranks may be hit in one cycle.
  always_comb begin
    ref_hit = '0;
    for (int r = 0; r < NUM_RANKS; r++)
      ref_hit[r] = run && is_ref_cmd(csbar_pad[r], rasbar_pad, casbar_pad, webar_pad);
  end

  // Tick timer next state: frozen while CKE is low, wraps on the tick.
  always_comb begin
    tmr_d = tmr_q;
    if (run)
      tmr_d = tick ? '0 : tmr_q + TMR_W'(1);
  end

  // First-error capture: lowest rank with a flag in the cycle err_any rises.
  always_comb begin
    err_any_d = err_any_q | (|err_next);
    first_d   = first_q;
    if (!err_any_q && (|err_next)) begin
      for (int r = NUM_RANKS - 1; r >= 0; r--)
        if (err_next[r]) first_d = 3'(r);
    end
  end

  // Top-level registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      tmr_q     <= '0;
      err_any_q <= 1'b0;
      first_q   <= '0;
    end else begin
      tmr_q     <= tmr_d;
      err_any_q <= err_any_d;
      first_q   <= first_d;
    end
  end

  for (genvar g = 0; g < NUM_RANKS; g++) begin : g_rank
    ddr2_ref_rank_tracker #(
      .TRFC_CLK     (TRFC_CLK),
      .MAX_POSTPONE (MAX_POSTPONE),
      .MAX_PULLIN   (MAX_PULLIN),
      .CRED_W       (CRED_W),
      .CNT_W        (CNT_W)
    ) u_trk (
      .clk            (clk),
      .clear_i        (clear),
      .tick_i         (tick),
      .ref_hit_i      (ref_hit[g]),
      .credit_o       (credit_o[g*CRED_W +: CRED_W]),
      .ref_count_o    (ref_count_o[g*CNT_W +: CNT_W]),
      .err_postpone_o (err_postpone_o[g]),
      .err_pullin_o   (err_pullin_o[g]),
      .err_trfc_o     (err_trfc_o[g]),
      .err_next_o     (err_next[g])
    );
  end

  assign err_any_o        = err_any_q;
  assign first_err_rank_o = first_q;

endmodule

// File: doc/ddr2_refresh_credit_monitor.md
Name: ddr2_refresh_credit_monitor

Overview:
Passive, multi-rank DDR2 AUTO REFRESH checker for the test bench. It decodes the command pins per chip-select and keeps a signed refresh-credit balance per rank against a free-running tREFI tick. It flags postponement or pull-in beyond the allowed limits and REF-to-REF spacing below tRFC. Errors are reported as sticky output flags, not simulator aborts, so benches can choose their policy. It sits beside the controller pads, in parallel with the other protocol monitors.

Parameters:
NUM_RANKS, 2, number of chip-selects/ranks monitored (1..8)
TREFI_CLK, 7800, controller clocks per refresh obligation tick (>=2)
TRFC_CLK, 26, minimum clocks between two REF commands to the same rank
MAX_POSTPONE, 8, maximum owed refreshes allowed before an error
MAX_PULLIN, 8, maximum refreshes issued ahead of schedule before an error
CRED_W, 5, signed credit width; must hold +/-(max(MAX_POSTPONE,MAX_PULLIN)+1)
CNT_W, 16, per-rank refresh event counter width

Ports:
clk  in  1  controller clock
reset  in  1  synchronous, active-high
ready_i  in  1  controller initialised; monitoring is enabled only while high
cke_pad  in  1  shared clock enable
csbar_pad  in  NUM_RANKS  per-rank chip select, active low
rasbar_pad  in  1  RAS#
casbar_pad  in  1  CAS#
webar_pad  in  1  WE#
credit_o  out  NUM_RANKS*CRED_W  signed owed-refresh balance per rank (positive = owed)
ref_count_o  out  NUM_RANKS*CNT_W  REF commands seen per rank since ready, saturating
err_postpone_o  out  NUM_RANKS  sticky: credit exceeded +MAX_POSTPONE
err_pullin_o  out  NUM_RANKS  sticky: credit below -MAX_PULLIN
err_trfc_o  out  NUM_RANKS  sticky: REF spacing < TRFC_CLK
err_any_o  out  1  OR of all sticky flags
first_err_rank_o  out  3  rank index of the first error ever flagged; valid only when err_any_o=1

Behaviour:
- Reset, or ready_i=0: all credits 0, counters 0, tick timer 0, spacing timers saturated (no tRFC error on the first REF), all error flags 0, first_err_rank_o=0. Dropping ready_i mid-run clears everything, errors included.
- REF decode for rank r: cke_pad & !csbar_pad[r] & !ras & !cas & webar_pad. Several ranks may be selected in one cycle; each selected rank registers a REF.
- Tick timer counts only while ready_i & cke_pad. When it reaches TREFI_CLK-1 it wraps to 0 and raises a one-cycle tick. The tick increments every rank's credit. CKE low (power-down/self-refresh) freezes the timer; credits hold.
- REF to rank r decrements credit[r]. A tick and a REF in the same cycle leave the credit unchanged.
- Credit arithmetic is signed CRED_W and saturates at +/-(2^(CRED_W-1)-1); it never wraps.
- err_postpone[r] sets the cycle after credit[r] becomes > MAX_POSTPONE. err_pullin[r] sets the cycle after credit[r] becomes < -MAX_PULLIN. Both use registered comparison of the updated value, giving 1-cycle latency.
- Per-rank spacing timer: cleared on REF to that rank, otherwise incrementing and saturating at TRFC_CLK. If a REF arrives while the timer is < TRFC_CLK-1, i.e. fewer than TRFC_CLK cycles since the previous REF edge, err_trfc[r] sets on the next cycle.
- Sticky flags clear only on reset or ready_i=0.
- first_err_rank_o latches the lowest-index rank with a new error in the first cycle err_any transitions 0->1, then holds.
- ref_count_o increments on each REF and saturates at all-ones.
- All outputs are registered. The block never drives the pads.

Decomposition:
- Shared package ddr2_mon_pkg: REF command encoding (CS/RAS/CAS/WE = 0001) and the credit saturation limit function.
- Sub-module ddr2_ref_rank_tracker, instantiated NUM_RANKS times. It holds the credit, spacing timer, counter and three sticky flags for one rank, taking tick and ref_hit as inputs.
- The top level holds the tick timer, command decode and the error-priority latch.

Test Plan:
- Regular refresh: NUM_RANKS=2, TREFI_CLK=100; REF to both ranks every 100 cycles, 20 times -> credits stay in {0,1}, ref_count=20, no error flags.
- Postpone limit: no REF for 8 ticks -> credit=8, no error; ninth tick -> credit=9, err_postpone[0] and [1] set 1 cycle later, first_err_rank_o=0.
- Pull-in limit: 9 REFs to rank 1 spaced 30 cycles apart before any tick -> credit[1]=-9, err_pullin[1] only, first_err_rank_o=1.
- tRFC violation: REF rank 0, then again 20 cycles later (TRFC_CLK=26) -> err_trfc[0]=1; the same pattern at 26 cycles -> no error.
- CKE low for 1000 cycles mid-run -> tick timer and credits frozen, no postpone error; the count resumes where it left off after CKE rises.
- Simultaneous tick and REF to rank 0, then ready_i dropped with errors set -> credit unchanged in that cycle; all outputs return to reset values the next cycle.
